instruction_sequencer: RTL and testbench

- Initiator side of the datapath instruction handshake (instruction / start / finished / result).
- Fetches instruction words from a synchronous program ROM and executes two opcodes itself: HALT and JUMP.
- Issues draw, mem-read and mem-write opcodes to the datapath one at a time and waits for completion.
- Captures read results. Sits between the top-level control (run/status) and the datapath.

---
 rtl/instruction_sequencer.sv | 168 ++++++++++++++++
 tb/tb_instruction_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Purpose: fetches program words from a sync ROM, runs HALT/JUMP locally, dispatches opcodes 1-3 to the datapath.
// Latency: FETCH+DECODE per word; dispatched words add ISSUE, WAIT_ACK and WAIT_DONE (>=5 cycles plus datapath time).
// Backpressure: one instruction in flight; waits on dp_finished levels, with an optional timeout raising error.
module instruction_sequencer #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 4,
  parameter int RESULT_W = 12,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [ADDR_W-1:0]   start_addr,
  output logic                busy,
  output logic                halted,
  output logic                error,
  output logic [ADDR_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  output logic [INSTR_W-1:0]  dp_instruction,
  output logic                dp_start,
  input  logic                dp_finished,
  input  logic [RESULT_W-1:0] dp_result,
  output logic [RESULT_W-1:0] last_result,
  output logic [15:0]         instr_count
);

  // Timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_DRAW  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_READ  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_WRITE = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic                halted_n, error_n, dp_start_n;
  logic [INSTR_W-1:0]  instr_n;
  logic [RESULT_W-1:0] result_n;
  logic [15:0]         count_n;
  logic [TW-1:0]       timer, timer_n;

  logic [OPCODE_W-1:0] decode_op;
  logic                held_is_read;
  logic                timeout_hit;
  logic [15:0]         count_inc;

  assign decode_op    = prog_data[INSTR_W-1 -: OPCODE_W];
  assign held_is_read = (dp_instruction[INSTR_W-1 -: OPCODE_W] == OP_READ);
  assign timeout_hit  = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign count_inc    = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

  assign busy      = (state != S_IDLE);
  assign prog_addr = pc;

  // Next-state and next-register values; everything holds unless a state says otherwise.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    halted_n = halted;
    error_n  = error;
    instr_n  = dp_instruction;
    result_n = last_result;
    count_n  = instr_count;
    timer_n  = timer;
    case (state)
      S_IDLE: begin
        if (run) begin
          pc_n     = start_addr;
          halted_n = 1'b0;
          error_n  = 1'b0;
          count_n  = 16'd0;
          state_n  = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        case (decode_op)
          OP_HALT: begin
            halted_n = 1'b1;
            state_n  = S_IDLE;
          end
          OP_JUMP: begin
            pc_n    = prog_data[ADDR_W-1:0];
            count_n = count_inc;
            state_n = S_FETCH;
          end
          OP_DRAW, OP_READ, OP_WRITE: begin
            instr_n = prog_data;
            state_n = S_ISSUE;
          end
          default: begin
            error_n = 1'b1;
            state_n = S_IDLE;
          end
        endcase
      end
      S_ISSUE: begin
        timer_n = '0;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!dp_finished) begin
          timer_n = '0;
          state_n = S_WAIT_DONE;
        end else if (timeout_hit) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (dp_finished) begin
          if (held_is_read) result_n = dp_result;
          pc_n    = pc + ADDR_W'(1);
          count_n = count_inc;
          state_n = S_FETCH;
        end else if (timeout_hit) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Registered start pulse: high exactly during the ISSUE cycle.
    dp_start_n = (state_n == S_ISSUE);
  end

  // State and output registers; reset aborts any in-flight dispatch by dropping dp_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      pc             <= '0;
      halted         <= 1'b0;
      error          <= 1'b0;
      dp_start       <= 1'b0;
      dp_instruction <= '0;
      last_result    <= '0;
      instr_count    <= 16'd0;
      timer          <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      halted         <= halted_n;
      error          <= error_n;
      dp_start       <= dp_start_n;
      dp_instruction <= instr_n;
      last_result    <= result_n;
      instr_count    <= count_n;
      timer          <= timer_n;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Purpose: directed bench for instruction_sequencer with a program-level reference model.
// Latency: ROM answers one cycle after the address; datapath drops finished 1 cycle after start, raises it 2 later.
// Backpressure: datapath model can be held stuck (finished stays high) to exercise the timeout.
module tb_instruction_sequencer;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  start_addr = 8'd0;
  logic        busy, halted, error, dp_start;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data = 32'd0;
  logic [31:0] dp_instruction;
  logic        dp_finished = 1'b1;
  logic [11:0] dp_result = 12'd0;
  logic [11:0] last_result;
  logic [15:0] instr_count;

  logic [31:0] rom [256];
  logic [11:0] rd_val = 12'hABC;
  bit          dp_stuck = 1'b0;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Program-level model results
  logic [31:0] exp_q[$];
  logic [7:0]  exp_vis[$];
  logic [7:0]  vis_q[$];
  bit          exp_halt, exp_err;
  int          exp_cnt;
  logic [11:0] m_lr = 12'd0;

  always #5 clock = ~clock;

  instruction_sequencer #(
    .INSTR_W(32), .OPCODE_W(4), .RESULT_W(12), .ADDR_W(8), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .start_addr(start_addr),
    .busy(busy), .halted(halted), .error(error),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dp_instruction(dp_instruction), .dp_start(dp_start),
    .dp_finished(dp_finished), .dp_result(dp_result),
    .last_result(last_result), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Interprets the program from sa the way the sequencer should, one instruction at a time.
  task automatic model_run(input logic [7:0] sa, input bit stuck);
    logic [7:0]  pc;
    logic [31:0] w;
    bit          done;
    pc = sa;
    done = 0;
    exp_q.delete();
    exp_vis.delete();
    exp_halt = 0;
    exp_err = 0;
    exp_cnt = 0;
    for (int s = 0; s < 64 && !done; s++) begin
      w = rom[pc];
      if (exp_vis.size() == 0 || exp_vis[$] != pc) exp_vis.push_back(pc);
      case (w[31:28])
        4'd0: begin exp_halt = 1; done = 1; end
        4'd4: begin pc = w[7:0]; exp_cnt++; end
        4'd1, 4'd2, 4'd3: begin
          exp_q.push_back(w);
          if (stuck) begin
            exp_err = 1;
            done = 1;
          end else begin
            if (w[31:28] == 4'd2) m_lr = rd_val;
            pc = pc + 8'd1;
            exp_cnt++;
          end
        end
        default: begin exp_err = 1; done = 1; end
      endcase
    end
  endtask

  // Synchronous ROM: word for the address held during the previous cycle.
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge clock);
      a = prog_addr;
      @(posedge clock);
      #1 prog_data = rom[a];
    end
  end

  // Datapath responder: acknowledges by dropping finished, completes two cycles later.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clock);
      if (dp_start && !dp_stuck && !reset) begin
        w = dp_instruction;
        @(posedge clock);
        #1 dp_finished = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        dp_result = (w[31:28] == 4'd2) ? rd_val : ~rd_val;
        dp_finished = 1'b1;
      end
    end
  end

  // Per-cycle compare: dispatch order against the model, start-pulse rules, fetched address trace.
  initial begin
    bit prev_start;
    prev_start = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dp_start) begin
          chk("start_while_busy", {31'd0, busy}, 32'd1);
          chk("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
          chk("start_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) chk("dp_instruction", dp_instruction, exp_q.pop_front());
          pulses++;
        end
        if (!busy) chk("no_start_when_idle", {31'd0, dp_start}, 32'd0);
        if (busy && (vis_q.size() == 0 || vis_q[$] != prog_addr)) vis_q.push_back(prog_addr);
        prev_start = dp_start;
      end else begin
        prev_start = 0;
      end
    end
  end

  task automatic start_run(input logic [7:0] sa, input bit stuck);
    model_run(sa, stuck);
    vis_q.delete();
    pulses = 0;
    @(negedge clock);
    start_addr = sa;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
  endtask

  task automatic finish_run();
    for (int n = 0; n < 500 && busy; n++) @(negedge clock);
    chk("run_completes", {31'd0, busy}, 32'd0);
    chk("halted", {31'd0, halted}, {31'd0, exp_halt});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("instr_count", {16'd0, instr_count}, exp_cnt);
    chk("last_result", {20'd0, last_result}, {20'd0, m_lr});
    chk("all_dispatched", exp_q.size(), 32'd0);
    chk("visit_len", vis_q.size(), exp_vis.size());
    for (int i = 0; i < exp_vis.size() && i < vis_q.size(); i++)
      chk("visit_addr", {24'd0, vis_q[i]}, {24'd0, exp_vis[i]});
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clock);
      if (dp_start) seen = 1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_dp_start"}, {31'd0, dp_start}, 32'd0);
    chk({tag, "_dp_instruction"}, dp_instruction, 32'd0);
    chk({tag, "_last_result"}, {20'd0, last_result}, 32'd0);
    chk({tag, "_instr_count"}, {16'd0, instr_count}, 32'd0);
    chk({tag, "_prog_addr"}, {24'd0, prog_addr}, 32'd0);
  endtask

  initial begin
    clear_rom();
    #1 reset = 1'b1;
    #10;
    chk_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;

    // 1: single draw then HALT
    rom[0] = 32'h1012_3456;
    rom[1] = 32'h0000_0000;
    start_run(8'd0, 0);
    finish_run();
    chk("t1_pulses", pulses, 32'd1);
    chk("t1_dp_instruction", dp_instruction, 32'h1012_3456);
    chk("t1_count", {16'd0, instr_count}, 32'd1);
    chk("t1_halted", {31'd0, halted}, 32'd1);

    // 2: read then write; write must not disturb last_result
    clear_rom();
    rom[0] = 32'h2000_0010;
    rom[1] = 32'h3ABC_0011;
    start_run(8'd0, 0);
    wait_start("t2_first_start");
    wait_start("t2_second_start");
    chk("t2_lr_after_read", {20'd0, last_result}, 32'h0000_0ABC);
    finish_run();
    chk("t2_lr_after_write", {20'd0, last_result}, 32'h0000_0ABC);
    chk("t2_count", {16'd0, instr_count}, 32'd2);

    // 3: JUMP 5 then HALT
    clear_rom();
    rom[0] = 32'h4000_0005;
    start_run(8'd0, 0);
    finish_run();
    chk("t3_pulses", pulses, 32'd0);
    chk("t3_prog_addr", {24'd0, prog_addr}, 32'd5);
    chk("t3_count", {16'd0, instr_count}, 32'd1);

    // 4: illegal opcode, then a valid run clears error
    clear_rom();
    rom[0] = 32'h7000_0000;
    start_run(8'd0, 0);
    finish_run();
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_pulses", pulses, 32'd0);
    rom[0] = 32'h1000_0001;
    start_run(8'd0, 0);
    finish_run();
    chk("t4_error_cleared", {31'd0, error}, 32'd0);

    // 5: stuck datapath -> timeout; a run pulse during the wait is ignored
    clear_rom();
    rom[8'h10] = 32'h1000_0077;
    dp_stuck = 1;
    start_run(8'h10, 1);
    wait_start("t5_start");
    begin
      int n;
      n = 0;
      // Wait spans TO cycles after ISSUE, so error appears at the (TO+1)th sample after the start pulse.
      while (n < 100 && !error) begin
        @(negedge clock);
        n++;
        if (n == 5) begin start_addr = 8'h40; run = 1'b1; end
        else run = 1'b0;
      end
      run = 1'b0;
      chk("t5_timeout_cycles", n, TO + 1);
    end
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_prog_addr", {24'd0, prog_addr}, 32'h10);
    finish_run();
    dp_stuck = 0;

    // 6: pc wrap from 255, then reset during WAIT_DONE
    clear_rom();
    rom[255] = 32'h1000_00FF;
    start_run(8'd255, 0);
    finish_run();
    chk("t6_count", {16'd0, instr_count}, 32'd1);
    chk("t6_wrapped_pc", {24'd0, prog_addr}, 32'd0);
    start_run(8'd255, 0);
    wait_start("t6_start");
    repeat (2) @(negedge clock);
    chk("t6_dp_finished_low", {31'd0, dp_finished}, 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_values("t6_midreset");
    @(negedge clock);
    chk("t6_start_held_low", {31'd0, dp_start}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    m_lr = 12'd0;
    repeat (4) @(negedge clock);
    chk("t6_stays_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
